// File: rtl/uart_pkg.sv
// Shared types and constants for the board UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned SYSCLK_HZ        = 27000000;
    localparam int unsigned BAUD             = 1000000;
    localparam int unsigned CLKS_PER_BIT_DEF = (SYSCLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CNT_W            = 9;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned DATA_W           = 8;

    // Two-of-three vote used when sample filtering is enabled.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; both stages reset to 1 (idle line level).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with mid-bit sampling and framing-error strobe.
// Optional 3-sample majority filter on every bit sample: define UART_RX_MAJORITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_bsy
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              w_rx_s;
    logic              w_bit;

    rx_state_t         r_state;
    rx_state_t         w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nx;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nx;
    logic              r_valid;
    logic              w_valid_nx;
    logic              r_ferr;
    logic              w_ferr_nx;
    logic              r_bsy;
    logic              w_bsy_nx;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // rx_s at t-1 (bit 0) and t-2 (bit 1); idle level after reset.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = majority3(w_rx_s, r_hist[0], r_hist[1]);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_bsy   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shreg <= w_shreg_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_bsy   <= w_bsy_nx;
        end
    end

    // cnt doubles as the high-run counter in WAIT_HIGH and the bit timer elsewhere.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shreg_nx = r_shreg;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_ferr_nx  = 1'b0;

        case (r_state)
            WAIT_HIGH: begin
                if (!w_rx_s) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == BIT_END) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                w_cnt_nx = '0;
                if (!w_rx_s) begin
                    w_state_nx = START;
                end
            end
            START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_nx = '0;
                    if (!w_bit) begin
                        w_idx_nx   = '0;
                        w_state_nx = DATA;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx          = '0;
                    w_shreg_nx[r_idx] = w_bit;
                    w_idx_nx          = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = STOP;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx = '0;
                    if (w_bit) begin
                        w_data_nx  = r_shreg;
                        w_valid_nx = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = WAIT_HIGH;
            end
        endcase

        w_bsy_nx = (w_state_nx == START) || (w_state_nx == DATA) || (w_state_nx == STOP);
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_bsy       = r_bsy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model plus directed frames with literal expectations.
module tb_uart_rx;

    localparam int C = 27;
    localparam int H = 13;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_bsy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Expected outputs produced by the reference model.
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_bsy   = 1'b0;
    // Model view of the synchronised line: s2 is what the receiver sees this edge, s3/s4 older.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_s3 = 1'b1, m_s4 = 1'b1;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         bsy_cnt   = 0;
    int         vcyc[$];
    logic [7:0] vdat[$];
    int         last_fall = 0;

    uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_bsy       (rx_bsy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a && b) || (a && c) || (b && c);
    endfunction

    // One receiver clock edge as seen by the model; ab reports an asynchronous reset.
    task automatic tick(output bit ab, output logic raw, output logic smp);
        @(posedge clk or negedge rst_n);
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        ab  = !rst_n;
        raw = m_s2;
`ifdef UART_RX_MAJORITY_EN
        smp = maj3(m_s2, m_s3, m_s4);
`else
        smp = m_s2;
`endif
        if (!ab) begin
            m_s4 = m_s3;
            m_s3 = m_s2;
            m_s2 = m_s1;
            m_s1 = rx;
        end
    endtask

    // Behaviour from reset release until a reset or a framing error.
    task automatic model_session();
        bit         ab;
        logic       raw, smp;
        int         run;
        logic [7:0] b;
        run = 0;
        while (run < C) begin
            tick(ab, raw, smp);
            if (ab) return;
            run = raw ? run + 1 : 0;
        end
        forever begin
            do begin
                tick(ab, raw, smp);
                if (ab) return;
            end while (raw);
            m_bsy = 1'b1;
            repeat (H) begin
                tick(ab, raw, smp);
                if (ab) return;
            end
            if (smp) begin
                m_bsy = 1'b0;
                continue;
            end
            b = 8'h00;
            for (int n = 0; n < 8; n++) begin
                repeat (C) begin
                    tick(ab, raw, smp);
                    if (ab) return;
                end
                b[n] = smp;
            end
            repeat (C) begin
                tick(ab, raw, smp);
                if (ab) return;
            end
            m_bsy = 1'b0;
            if (smp) begin
                m_data  = b;
                m_valid = 1'b1;
            end else begin
                m_ferr = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        forever begin
            if (!rst_n) begin
                m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_bsy = 1'b0;
                m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1; m_s4 = 1'b1;
                wait (rst_n === 1'b1);
            end
            model_session();
        end
    end

    // Per-cycle comparison against the model and strobe bookkeeping.
    always begin
        @(posedge clk);
        #3;
        chk("rx_data",      32'(rx_data),      32'(m_data));
        chk("rx_valid",     32'(rx_valid),     32'(m_valid));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
        chk("rx_bsy",       32'(rx_bsy),       32'(m_bsy));
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            vcyc.push_back(cyc);
            vdat.push_back(rx_data);
        end
        if (rx_frame_err === 1'b1) ferr_cnt++;
        if (rx_bsy === 1'b1) bsy_cnt++;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gl_bit);
        last_fall = cyc;
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) begin
            if (i == gl_bit) begin
                drive(b[i], H);
                drive(~b[i], 1);
                drive(b[i], C - H - 1);
            end else begin
                drive(b[i], C);
            end
        end
        drive(stop_v, C);
    endtask

    initial begin
        logic [7:0] c3;
        int         a5_fall;
        c3 = 8'hC3;
        @(negedge clk);
        drive(1'b1, 3);
        chk("reset_data",  32'(rx_data),      32'h0);
        chk("reset_valid", 32'(rx_valid),     32'h0);
        chk("reset_ferr",  32'(rx_frame_err), 32'h0);
        chk("reset_bsy",   32'(rx_bsy),       32'h0);
        rst_n = 1'b1;
        drive(1'b1, 30);

        send_frame(8'hA5, 1'b1, -1);
        a5_fall = last_fall;
        drive(1'b1, 5);
        chk("a5_count",   32'(valid_cnt), 32'd1);
        chk("a5_latency", 32'(vcyc[0] - a5_fall), 32'd259);
        chk("a5_data",    32'(vdat[0]), 32'hA5);
        chk("a5_no_ferr", 32'(ferr_cnt), 32'd0);

        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        drive(1'b1, 5);
        chk("b2b_count",  32'(valid_cnt), 32'd4);
        chk("b2b_data0",  32'(vdat[1]), 32'h00);
        chk("b2b_data1",  32'(vdat[2]), 32'hFF);
        chk("b2b_data2",  32'(vdat[3]), 32'h3C);
        chk("b2b_gap01",  32'(vcyc[2] - vcyc[1]), 32'd270);
        chk("b2b_gap12",  32'(vcyc[3] - vcyc[2]), 32'd270);

        send_frame(8'h5A, 1'b0, -1);
        drive(1'b0, 100);
        chk("ferr_count",   32'(ferr_cnt),  32'd1);
        chk("ferr_novalid", 32'(valid_cnt), 32'd4);
        chk("ferr_hold",    32'(rx_data),   32'h3C);
        drive(1'b1, C);
        send_frame(8'h11, 1'b1, -1);
        drive(1'b1, 5);
        chk("rearm_count", 32'(valid_cnt), 32'd5);
        chk("rearm_data",  32'(rx_data),   32'h11);

        drive(1'b1, 30);
        bsy_cnt = 0;
        drive(1'b0, 5);
        drive(1'b1, 40);
        chk("glitch_bsy",    32'(bsy_cnt),   32'd13);
        chk("glitch_nvalid", 32'(valid_cnt), 32'd5);
        chk("glitch_nferr",  32'(ferr_cnt),  32'd1);

        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(c3[i], C);
        drive(c3[4], 10);
        chk("pre_rst_bsy", 32'(rx_bsy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_bsy",   32'(rx_bsy),       32'h0);
        chk("rst_data",  32'(rx_data),      32'h0);
        chk("rst_valid", 32'(rx_valid),     32'h0);
        chk("rst_ferr",  32'(rx_frame_err), 32'h0);
        @(negedge clk);
        drive(1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 30);
        chk("rst_nstrobe", 32'(valid_cnt), 32'd5);
        send_frame(8'hC3, 1'b1, -1);
        drive(1'b1, 5);
        chk("c3_count", 32'(valid_cnt), 32'd6);
        chk("c3_data",  32'(rx_data),   32'hC3);

        drive(1'b1, 30);
        send_frame(8'h0F, 1'b1, 2);
        drive(1'b1, 5);
        chk("glitch_bit2_count", 32'(valid_cnt), 32'd7);
`ifdef UART_RX_MAJORITY_EN
        chk("glitch_bit2_data", 32'(rx_data), 32'h0F);
`else
        chk("glitch_bit2_data", 32'(rx_data), 32'h0B);
`endif
        chk("final_ferr", 32'(ferr_cnt), 32'd1);
        drive(1'b1, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
